fetch_decode_execute: RTL and testbench

FETCH_DECODE_EXECUTE -- requirements
Module: fetch_decode_execute

---
 rtl/fetch_decode_execute.sv | 231 +++++++++++++++++++++++
 tb/tb_fetch_decode_execute.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_execute.sv
// Single-cycle LEGv8-style fetch/decode/execute core.
//
// Every instruction except MUL retires in one cycle. The instruction word and the load
// data are combinational inputs that must be valid for the current pc in the same cycle.
//
// Optional feature: define FDE_MULTIPLIER_EN to build the iterative shift-add MUL unit.
// Without it, MUL executes as a one-cycle NOP and stall is tied low.
//
// Ports:
//   clk         - clock; all state updates on the rising edge
//   reset       - synchronous, active-high reset
//   pc          - current pc, also the instruction-memory byte address
//   instruction - instruction word at pc
//   mem_addr    - data address, Rn + sign-extended DT offset
//   mem_read    - LDUR strobe
//   mem_write   - STUR strobe
//   mem_wdata   - STUR store data (Rt)
//   mem_rdata   - LDUR load data
//   stall       - a multicycle MUL is in progress
//   flags       - {N, Z, C, V}
module fetch_decode_execute #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pc,
  input  logic [31:0] instruction,
  output logic [63:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic [3:0]  flags
);

  logic [63:0] regs_q [32];
  logic [63:0] pc_q, pc_d;
  logic [3:0]  flags_q, flags_d;

  logic [10:0] opcode;
  logic [4:0]  rn_idx, rm_idx, rt_idx;
  logic [5:0]  shamt;
  logic [63:0] rn_val, rm_val, rt_val;
  logic [63:0] imm12, dt_off, cb_off, b_off;
  logic [64:0] add_rr, sub_rr;
  logic        add_v, sub_v;
  logic        n_f, z_f, c_f, v_f, cond_taken;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  assign opcode = instruction[31:21];
  assign rm_idx = instruction[20:16];
  assign shamt  = instruction[15:10];
  assign rn_idx = instruction[9:5];
  assign rt_idx = instruction[4:0];

  // X31 is the zero register on every read port.
  assign rn_val = (rn_idx == 5'd31) ? 64'd0 : regs_q[rn_idx];
  assign rm_val = (rm_idx == 5'd31) ? 64'd0 : regs_q[rm_idx];
  assign rt_val = (rt_idx == 5'd31) ? 64'd0 : regs_q[rt_idx];

  assign imm12  = {52'd0, instruction[21:10]};
  assign dt_off = {{55{instruction[20]}}, instruction[20:12]};
  assign cb_off = {{43{instruction[23]}}, instruction[23:5], 2'b00};
  assign b_off  = {{36{instruction[25]}}, instruction[25:0], 2'b00};

  // Subtraction as Rn + ~Rm + 1 so bit 64 is the ARM-style carry (1 = no borrow).
  assign add_rr = {1'b0, rn_val} + {1'b0, rm_val};
  assign sub_rr = {1'b0, rn_val} + {1'b0, ~rm_val} + 65'd1;
  assign add_v  = (rn_val[63] == rm_val[63]) && (add_rr[63] != rn_val[63]);
  assign sub_v  = (rn_val[63] != rm_val[63]) && (sub_rr[63] != rn_val[63]);

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_taken = 1'b1;
    unique case (rt_idx[3:0])
      4'd0:    cond_taken = z_f;
      4'd1:    cond_taken = !z_f;
      4'd2:    cond_taken = c_f;
      4'd3:    cond_taken = !c_f;
      4'd4:    cond_taken = n_f;
      4'd5:    cond_taken = !n_f;
      4'd6:    cond_taken = v_f;
      4'd7:    cond_taken = !v_f;
      4'd8:    cond_taken = c_f && !z_f;
      4'd9:    cond_taken = !(c_f && !z_f);
      4'd10:   cond_taken = (n_f == v_f);
      4'd11:   cond_taken = (n_f != v_f);
      4'd12:   cond_taken = !z_f && (n_f == v_f);
      4'd13:   cond_taken = !(!z_f && (n_f == v_f));
      default: cond_taken = 1'b1;
    endcase
  end

`ifdef FDE_MULTIPLIER_EN
  logic        mul_start;
  logic        mul_busy_q;
  logic [5:0]  mul_cnt_q;
  logic [63:0] mul_mcand_q, mul_mplier_q, mul_acc_q, mul_sum;
  logic [4:0]  mul_rd_q;

  assign mul_sum = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : 64'd0);
  assign stall   = mul_busy_q || (opcode == 11'b10011011000);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    pc_d      = pc_q + 64'd4;
    flags_d   = flags_q;
    rf_we     = 1'b0;
    rf_waddr  = rt_idx;
    rf_wdata  = 64'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
`ifdef FDE_MULTIPLIER_EN
    mul_start = 1'b0;
`endif
    casez (opcode)
      11'b10001011000: begin rf_we = 1'b1; rf_wdata = add_rr[63:0]; end     // ADD
      11'b11001011000: begin rf_we = 1'b1; rf_wdata = sub_rr[63:0]; end     // SUB
      11'b10001010000: begin rf_we = 1'b1; rf_wdata = rn_val & rm_val; end  // AND
      11'b10101010000: begin rf_we = 1'b1; rf_wdata = rn_val | rm_val; end  // ORR
      11'b10101011000: begin                                                // ADDS
        rf_we    = 1'b1;
        rf_wdata = add_rr[63:0];
        flags_d  = {add_rr[63], add_rr[63:0] == 64'd0, add_rr[64], add_v};
      end
      11'b11101011000: begin                                                // SUBS
        rf_we    = 1'b1;
        rf_wdata = sub_rr[63:0];
        flags_d  = {sub_rr[63], sub_rr[63:0] == 64'd0, sub_rr[64], sub_v};
      end
      11'b1001000100?: begin rf_we = 1'b1; rf_wdata = rn_val + imm12; end   // ADDI
      11'b1101000100?: begin rf_we = 1'b1; rf_wdata = rn_val - imm12; end   // SUBI
      11'b11111000010: begin                                                // LDUR
        mem_read = 1'b1;
        rf_we    = 1'b1;
        rf_wdata = mem_rdata;
      end
      11'b11111000000: mem_write = 1'b1;                                    // STUR
      11'b10110100???: if (rt_val == 64'd0) pc_d = pc_q + cb_off;           // CBZ
      11'b10110101???: if (rt_val != 64'd0) pc_d = pc_q + cb_off;           // CBNZ
      11'b000101?????: pc_d = pc_q + b_off;                                 // B
      11'b100101?????: begin                                                // BL
        pc_d     = pc_q + b_off;
        rf_we    = 1'b1;
        rf_waddr = 5'd30;
        rf_wdata = pc_q + 64'd4;
      end
      11'b11010110000: pc_d = rn_val;                                       // BR
      11'b01010100???: if (cond_taken) pc_d = pc_q + cb_off;                // B.cond
      11'b11010011011: begin rf_we = 1'b1; rf_wdata = rn_val << shamt; end  // LSL
      11'b11010011010: begin rf_we = 1'b1; rf_wdata = rn_val >> shamt; end  // LSR
`ifdef FDE_MULTIPLIER_EN
      11'b10011011000: begin                                                // MUL issue
        mul_start = !mul_busy_q;
        pc_d      = pc_q;
      end
`endif
      default: ;
    endcase
`ifdef FDE_MULTIPLIER_EN
    // While iterating, the architectural state is frozen regardless of the fetched word;
    // the last iteration retires the product and advances pc.
    if (mul_busy_q) begin
      pc_d      = pc_q;
      flags_d   = flags_q;
      rf_we     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mul_start = 1'b0;
      if (mul_cnt_q == 6'd63) begin
        pc_d     = pc_q + 64'd4;
        rf_we    = 1'b1;
        rf_waddr = mul_rd_q;
        rf_wdata = mul_sum;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      flags_q <= 4'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 64'd0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      if (rf_we && rf_waddr != 5'd31) regs_q[rf_waddr] <= rf_wdata;
    end
  end

`ifdef FDE_MULTIPLIER_EN
  // Operands are latched at issue so Rd may alias Rn or Rm.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_busy_q   <= 1'b0;
      mul_cnt_q    <= 6'd0;
      mul_mcand_q  <= 64'd0;
      mul_mplier_q <= 64'd0;
      mul_acc_q    <= 64'd0;
      mul_rd_q     <= 5'd0;
    end else if (mul_start) begin
      mul_busy_q   <= 1'b1;
      mul_cnt_q    <= 6'd0;
      mul_mcand_q  <= rn_val;
      mul_mplier_q <= rm_val;
      mul_acc_q    <= 64'd0;
      mul_rd_q     <= rt_idx;
    end else if (mul_busy_q) begin
      mul_acc_q    <= mul_sum;
      mul_mcand_q  <= mul_mcand_q << 1;
      mul_mplier_q <= mul_mplier_q >> 1;
      mul_cnt_q    <= mul_cnt_q + 6'd1;
      if (mul_cnt_q == 6'd63) mul_busy_q <= 1'b0;
    end
  end
`endif

  assign pc        = pc_q;
  assign flags     = flags_q;
  assign mem_addr  = rn_val + dt_off;
  assign mem_wdata = rt_val;

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Self-checking bench for fetch_decode_execute. A reference model executes each
// instruction at the ISA level and queues the outputs the core must show in that cycle;
// a monitor on the falling edge pops and compares. Register contents are observed
// through STUR (mem_wdata). Honours FDE_MULTIPLIER_EN like the design.
module tb_fetch_decode_execute;

  logic        clk;
  logic        reset;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic [63:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stall;
  logic [3:0]  flags;

  fetch_decode_execute #(.RESET_PC(64'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instruction(instruction),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  flags;
    logic        stall;
    logic        mrd;
    logic        mwr;
    logic [63:0] addr;
    logic [63:0] wdata;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference architectural state
  logic [63:0] m_x [32];
  logic [63:0] m_pc;
  logic [3:0]  m_flags;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", name, act, want, $time);
  endfunction

  always @(negedge clk) begin
    if (!reset && q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("flags", {60'd0, flags}, {60'd0, e.flags});
      chk("stall", {63'd0, stall}, {63'd0, e.stall});
      chk("mem_read", {63'd0, mem_read}, {63'd0, e.mrd});
      chk("mem_write", {63'd0, mem_write}, {63'd0, e.mwr});
      if (e.mwr) begin
        chk("st_addr", mem_addr, e.addr);
        chk("st_data", mem_wdata, e.wdata);
      end
      if (e.mrd) chk("ld_addr", mem_addr, e.addr);
    end
  end

  // Encoders
  function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm, logic [5:0] sh,
                                        logic [4:0] rn, logic [4:0] rd);
    return {op, rm, sh, rn, rd};
  endfunction
  function automatic logic [31:0] enc_i(logic [9:0] op, logic [11:0] imm, logic [4:0] rn,
                                        logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] dt, logic [4:0] rn,
                                        logic [4:0] rt);
    return {op, dt, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_b(logic [5:0] op, logic [25:0] off);
    return {op, off};
  endfunction
  function automatic logic [31:0] enc_cb(logic [7:0] op, logic [18:0] off, logic [4:0] rt);
    return {op, off, rt};
  endfunction

  localparam logic [10:0] OpAdd = 11'h458, OpSub = 11'h658, OpAnd = 11'h450, OpOrr = 11'h550;
  localparam logic [10:0] OpAdds = 11'h558, OpSubs = 11'h758, OpLdur = 11'h7C2;
  localparam logic [10:0] OpStur = 11'h7C0, OpBr = 11'h6B0, OpLsl = 11'h69B, OpLsr = 11'h69A;
  localparam logic [10:0] OpMul = 11'h4D8;
  localparam logic [9:0]  OpAddi = 10'h244, OpSubi = 10'h344;
  localparam logic [7:0]  OpCbz = 8'hB4, OpCbnz = 8'hB5, OpBcond = 8'h54;
  localparam logic [5:0]  OpB = 6'h05, OpBl = 6'h25;

  function automatic logic [63:0] rreg(logic [4:0] i);
    return (i == 5'd31) ? 64'd0 : m_x[i];
  endfunction

  function automatic logic [63:0] sext(logic [63:0] v, int w);
    logic [63:0] m;
    m = 64'd1 << (w - 1);
    v = v & ((64'd1 << w) - 64'd1);
    return (v ^ m) - m;
  endfunction

  // Branch condition meaning in terms of N, Z, C, V
  function automatic logic cond_ok(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
    m_pc    = 64'h0;
    m_flags = 4'd0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instruction = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one instruction, queue the expected outputs for each cycle it occupies,
  // then commit its architectural effect to the model. Called at posedge + 1.
  task automatic issue(input logic [31:0] ins, input logic [63:0] rdata);
    exp_t e;
    logic [10:0] op;
    logic [63:0] a, b, t, res, npc, wval;
    logic [4:0]  wd;
    logic        wr, setf;
    logic [3:0]  nf;
    logic signed [65:0] sx, sr;
    int cycles;
    instruction = ins;
    mem_rdata   = rdata;
    op   = ins[31:21];
    a    = rreg(ins[9:5]);
    b    = rreg(ins[20:16]);
    t    = rreg(ins[4:0]);
    e.pc = m_pc; e.flags = m_flags; e.stall = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0;
    e.addr  = a + sext({55'd0, ins[20:12]}, 9);
    e.wdata = t;
    npc = m_pc + 64'd4; wr = 1'b0; wd = ins[4:0]; wval = 64'd0; setf = 1'b0; nf = m_flags;
    cycles = 1;
    if (op == OpAdd) begin wr = 1; wval = a + b; end
    else if (op == OpSub) begin wr = 1; wval = a - b; end
    else if (op == OpAnd) begin wr = 1; wval = a & b; end
    else if (op == OpOrr) begin wr = 1; wval = a | b; end
    else if (op == OpAdds || op == OpSubs) begin
      wr = 1; setf = 1;
      if (op == OpAdds) begin
        res = a + b;
        sx  = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        nf[1] = (res < a);
      end else begin
        res = a - b;
        sx  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        nf[1] = (a >= b);
      end
      sr = $signed({{2{res[63]}}, res});
      nf[3] = res[63]; nf[2] = (res == 64'd0); nf[0] = (sx != sr);
      wval = res;
    end
    else if (op >= 11'h488 && op <= 11'h489) begin wr = 1; wval = a + {52'd0, ins[21:10]}; end
    else if (op >= 11'h688 && op <= 11'h689) begin wr = 1; wval = a - {52'd0, ins[21:10]}; end
    else if (op == OpLdur) begin e.mrd = 1; wr = 1; wval = rdata; end
    else if (op == OpStur) e.mwr = 1;
    else if (op >= 11'h5A0 && op <= 11'h5A7) begin
      if (t == 0) npc = m_pc + sext({45'd0, ins[23:5]}, 19) * 4;
    end
    else if (op >= 11'h5A8 && op <= 11'h5AF) begin
      if (t != 0) npc = m_pc + sext({45'd0, ins[23:5]}, 19) * 4;
    end
    else if (op >= 11'h0A0 && op <= 11'h0BF) npc = m_pc + sext({38'd0, ins[25:0]}, 26) * 4;
    else if (op >= 11'h4A0 && op <= 11'h4BF) begin
      npc = m_pc + sext({38'd0, ins[25:0]}, 26) * 4;
      wr = 1; wd = 5'd30; wval = m_pc + 64'd4;
    end
    else if (op == OpBr) npc = a;
    else if (op >= 11'h2A0 && op <= 11'h2A7) begin
      if (cond_ok(ins[3:0], m_flags)) npc = m_pc + sext({45'd0, ins[23:5]}, 19) * 4;
    end
    else if (op == OpLsl) begin wr = 1; wval = a << ins[15:10]; end
    else if (op == OpLsr) begin wr = 1; wval = a >> ins[15:10]; end
`ifdef FDE_MULTIPLIER_EN
    else if (op == OpMul) begin wr = 1; wval = a * b; e.stall = 1; cycles = 65; end
`endif
    for (int k = 0; k < cycles; k++) begin
      q.push_back(e);
      @(posedge clk);
      #1;
    end
    if (wr && wd != 5'd31) m_x[wd] = wval;
    if (setf) m_flags = nf;
    m_pc = npc;
  endtask

  task automatic show(input logic [4:0] r);
    issue(enc_d(OpStur, 9'd0, 5'd31, r), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    mem_rdata = 64'd0;
    do_reset();
    // ADDI chain from reset
    issue(enc_i(OpAddi, 12'd5, 5'd31, 5'd1), 64'd0);
    issue(enc_i(OpAddi, 12'd7, 5'd1, 5'd2), 64'd0);
    show(5'd1);
    show(5'd2);
    // SUBS to zero then B.EQ
    issue(enc_i(OpAddi, 12'd3, 5'd31, 5'd1), 64'd0);
    issue(enc_r(OpSubs, 5'd1, 6'd0, 5'd1, 5'd3), 64'd0);
    issue(enc_cb(OpBcond, 19'd4, 5'd0), 64'd0);
    show(5'd3);
    // Store / load through X0 = 0x100
    issue(enc_i(OpAddi, 12'h100, 5'd31, 5'd0), 64'd0);
    issue(enc_d(OpStur, 9'd8, 5'd0, 5'd2), 64'd0);
    issue(enc_d(OpLdur, 9'd8, 5'd0, 5'd4), 64'hDEAD);
    show(5'd4);
    // BL from pc 0x20 then BR X30
    issue(enc_i(OpAddi, 12'h20, 5'd31, 5'd5), 64'd0);
    issue(enc_r(OpBr, 5'd0, 6'd0, 5'd5, 5'd0), 64'd0);
    issue(enc_b(OpBl, 26'd10), 64'd0);
    show(5'd30);
    issue(enc_r(OpBr, 5'd0, 6'd0, 5'd30, 5'd0), 64'd0);
    // Writes to X31 are discarded; MUL is a NOP without the multiplier
    issue(enc_i(OpAddi, 12'd9, 5'd31, 5'd31), 64'd0);
    show(5'd31);
    issue(enc_i(OpAddi, 12'd7, 5'd31, 5'd1), 64'd0);
    issue(enc_i(OpSubi, 12'd3, 5'd31, 5'd2), 64'd0);
    issue(enc_r(OpMul, 5'd2, 6'd0, 5'd1, 5'd3), 64'd0);
    show(5'd3);
    issue(enc_r(OpMul, 5'd1, 6'd0, 5'd1, 5'd1), 64'd0);
    show(5'd1);
`ifdef FDE_MULTIPLIER_EN
    // Reset part-way through a MUL
    do_reset();
    issue(enc_i(OpAddi, 12'd7, 5'd31, 5'd1), 64'd0);
    issue(enc_i(OpSubi, 12'd3, 5'd31, 5'd2), 64'd0);
    instruction = enc_r(OpMul, 5'd2, 6'd0, 5'd1, 5'd3);
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      e.pc = m_pc; e.flags = m_flags; e.stall = 1'b1; e.mrd = 1'b0; e.mwr = 1'b0;
      e.addr = 64'd0; e.wdata = 64'd0;
      q.push_back(e);
      @(posedge clk);
      #1;
    end
    do_reset();
    show(5'd3);
`endif
    // Randomised instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [4:0]  r1, r2, r3;
      logic [31:0] ins;
      int unsigned k;
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      r3 = 5'($urandom_range(0, 31));
      k  = $urandom_range(0, 19);
      case (k)
        0:  ins = enc_r(OpAdd, r1, 6'd0, r2, r3);
        1:  ins = enc_r(OpSub, r1, 6'd0, r2, r3);
        2:  ins = enc_r(OpAnd, r1, 6'd0, r2, r3);
        3:  ins = enc_r(OpOrr, r1, 6'd0, r2, r3);
        4:  ins = enc_r(OpAdds, r1, 6'd0, r2, r3);
        5:  ins = enc_r(OpSubs, r1, 6'd0, r2, r3);
        6:  ins = enc_i(OpAddi, 12'($urandom), r2, r3);
        7:  ins = enc_i(OpSubi, 12'($urandom), r2, r3);
        8:  ins = enc_d(OpLdur, 9'($urandom), r2, r3);
        9:  ins = enc_d(OpStur, 9'($urandom), r2, r3);
        10: ins = enc_cb(($urandom_range(0, 1) != 0) ? OpCbz : OpCbnz, 19'($urandom), r3);
        11: ins = enc_b(($urandom_range(0, 1) != 0) ? OpB : OpBl, 26'($urandom));
        12: ins = enc_r(OpBr, 5'd0, 6'd0, r2, 5'd0);
        13: ins = enc_cb(OpBcond, 19'($urandom), r3);
        14: ins = enc_r(OpLsl, 5'd0, 6'($urandom), r2, r3);
        15: ins = enc_r(OpLsr, 5'd0, 6'($urandom), r2, r3);
        16: ins = ($urandom_range(0, 3) == 0) ? enc_r(OpMul, r1, 6'd0, r2, r3) : 32'($urandom);
        default: ins = enc_d(OpStur, 9'($urandom), r2, r1);
      endcase
      issue(ins, {$urandom, $urandom});
    end
    instruction = 32'd0;
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
